// File: rtl/alu_sequencer.sv
// alu_sequencer
//   Multi-cycle control FSM that owns the 8-bit ALU and the register-file
//   ports around it. It accepts one two-address instruction
//   (Dst = Dst op Src) per valid/ready handshake and runs it through
//   READ -> EXEC -> WB. It also holds the architectural carry and zero flags.
//
// Ports
//   Clk, Reset                 rising-edge clock, async active-high reset
//   InstrValid/InstrReady      instruction handshake
//   InstrOp/Dst/Src/SetFlags   instruction fields (op 1010 = CMP, 1011+ illegal)
//   RegAddrA/B, RegDataA/B     register-file combinational read ports
//   AluDataA/B, AluSel,
//   AluWriteCZ                 ALU operands and control
//   AluDataOut, AluCF, AluZF   ALU result and flags
//   RegWrEn/WrAddr/WrData      register-file write port (written on Clk edge)
//   FlagC, FlagZ               architectural flags
//   Done, IllegalOp            one-cycle completion / illegal-op pulses
module alu_sequencer #(
  parameter int WIDTH_DATA_LENGTH   = 8,
  parameter int WIDTH_ALUSEL_LENGTH = 4,
  parameter int REG_ADDR_WIDTH      = 3
) (
  input  logic                           Clk,
  input  logic                           Reset,
  input  logic                           InstrValid,
  output logic                           InstrReady,
  input  logic [WIDTH_ALUSEL_LENGTH-1:0] InstrOp,
  input  logic [REG_ADDR_WIDTH-1:0]      InstrDst,
  input  logic [REG_ADDR_WIDTH-1:0]      InstrSrc,
  input  logic                           InstrSetFlags,
  output logic [REG_ADDR_WIDTH-1:0]      RegAddrA,
  output logic [REG_ADDR_WIDTH-1:0]      RegAddrB,
  input  logic [WIDTH_DATA_LENGTH-1:0]   RegDataA,
  input  logic [WIDTH_DATA_LENGTH-1:0]   RegDataB,
  output logic [WIDTH_DATA_LENGTH-1:0]   AluDataA,
  output logic [WIDTH_DATA_LENGTH-1:0]   AluDataB,
  output logic [WIDTH_ALUSEL_LENGTH-1:0] AluSel,
  output logic                           AluWriteCZ,
  input  logic [WIDTH_DATA_LENGTH-1:0]   AluDataOut,
  input  logic                           AluCF,
  input  logic                           AluZF,
  output logic                           RegWrEn,
  output logic [REG_ADDR_WIDTH-1:0]      RegWrAddr,
  output logic [WIDTH_DATA_LENGTH-1:0]   RegWrData,
  output logic                           FlagC,
  output logic                           FlagZ,
  output logic                           Done,
  output logic                           IllegalOp
);

  localparam logic [WIDTH_ALUSEL_LENGTH-1:0] OP_CMP  = 4'b1010;
  localparam logic [WIDTH_ALUSEL_LENGTH-1:0] SEL_SUB = 4'b0101;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_READ = 3'd1,
    S_EXEC = 3'd2,
    S_WB   = 3'd3,
    S_ERR  = 3'd4
  } state_t;

  state_t                           state_q, state_d;
  logic [WIDTH_ALUSEL_LENGTH-1:0]   op_q, op_d;
  logic [REG_ADDR_WIDTH-1:0]        dst_q, dst_d;
  logic [REG_ADDR_WIDTH-1:0]        src_q, src_d;
  logic                             set_flags_q, set_flags_d;
  logic [WIDTH_DATA_LENGTH-1:0]     opa_q, opa_d;
  logic [WIDTH_DATA_LENGTH-1:0]     opb_q, opb_d;
  logic [WIDTH_DATA_LENGTH-1:0]     result_q, result_d;
  logic                             flag_c_q, flag_c_d;
  logic                             flag_z_q, flag_z_d;

  logic is_cmp;
  logic accept;

  assign is_cmp = (op_q == OP_CMP);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= S_IDLE;
      op_q        <= '0;
      dst_q       <= '0;
      src_q       <= '0;
      set_flags_q <= 1'b0;
      opa_q       <= '0;
      opb_q       <= '0;
      result_q    <= '0;
      flag_c_q    <= 1'b0;
      flag_z_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      dst_q       <= dst_d;
      src_q       <= src_d;
      set_flags_q <= set_flags_d;
      opa_q       <= opa_d;
      opb_q       <= opb_d;
      result_q    <= result_d;
      flag_c_q    <= flag_c_d;
      flag_z_q    <= flag_z_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    dst_d       = dst_q;
    src_d       = src_q;
    set_flags_d = set_flags_q;
    opa_d       = opa_q;
    opb_d       = opb_q;
    result_d    = result_q;
    flag_c_d    = flag_c_q;
    flag_z_d    = flag_z_q;

    InstrReady  = 1'b0;
    AluSel      = '0;
    AluWriteCZ  = 1'b0;
    RegWrEn     = 1'b0;
    Done        = 1'b0;
    IllegalOp   = 1'b0;
    accept      = 1'b0;

    case (state_q)
      S_IDLE: begin
        InstrReady = 1'b1;
        accept     = InstrValid;
        state_d    = S_IDLE;
      end
      S_READ: begin
        opa_d   = RegDataA;
        opb_d   = RegDataB;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        // CMP is a subtract whose result is never written back.
        AluSel     = is_cmp ? SEL_SUB : op_q;
        AluWriteCZ = set_flags_q | is_cmp;
        result_d   = AluDataOut;
        if (set_flags_q | is_cmp) begin
          flag_c_d = AluCF;
          flag_z_d = AluZF;
        end
        state_d = S_WB;
      end
      S_WB: begin
        RegWrEn    = ~is_cmp;
        Done       = 1'b1;
        InstrReady = 1'b1;
        accept     = InstrValid;
        state_d    = S_IDLE;
      end
      S_ERR: begin
        IllegalOp = 1'b1;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Fields are latched on accept; the WB outputs above still use the
    // previous instruction's fields for this cycle.
    if (accept) begin
      op_d        = InstrOp;
      dst_d       = InstrDst;
      src_d       = InstrSrc;
      set_flags_d = InstrSetFlags;
      state_d     = (InstrOp <= OP_CMP) ? S_READ : S_ERR;
    end
  end

  // Read addresses always present the latched fields, so they are correct
  // during READ and simply hold elsewhere.
  assign RegAddrA  = dst_q;
  assign RegAddrB  = src_q;
  assign AluDataA  = opa_q;
  assign AluDataB  = opb_q;
  assign RegWrAddr = dst_q;
  assign RegWrData = result_q;
  assign FlagC     = flag_c_q;
  assign FlagZ     = flag_z_q;

endmodule

// File: tb/tb_alu_sequencer.sv
module tb_alu_sequencer;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       InstrValid = 1'b0;
  logic       InstrReady;
  logic [3:0] InstrOp = '0;
  logic [2:0] InstrDst = '0;
  logic [2:0] InstrSrc = '0;
  logic       InstrSetFlags = 1'b0;
  logic [2:0] RegAddrA, RegAddrB;
  logic [7:0] RegDataA, RegDataB;
  logic [7:0] AluDataA, AluDataB;
  logic [3:0] AluSel;
  logic       AluWriteCZ;
  logic [7:0] AluDataOut;
  logic       AluCF, AluZF;
  logic       RegWrEn;
  logic [2:0] RegWrAddr;
  logic [7:0] RegWrData;
  logic       FlagC, FlagZ, Done, IllegalOp;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_done_cyc = -100;

  always #5 Clk = ~Clk;

  alu_sequencer dut (
    .Clk(Clk), .Reset(Reset),
    .InstrValid(InstrValid), .InstrReady(InstrReady),
    .InstrOp(InstrOp), .InstrDst(InstrDst), .InstrSrc(InstrSrc),
    .InstrSetFlags(InstrSetFlags),
    .RegAddrA(RegAddrA), .RegAddrB(RegAddrB),
    .RegDataA(RegDataA), .RegDataB(RegDataB),
    .AluDataA(AluDataA), .AluDataB(AluDataB),
    .AluSel(AluSel), .AluWriteCZ(AluWriteCZ),
    .AluDataOut(AluDataOut), .AluCF(AluCF), .AluZF(AluZF),
    .RegWrEn(RegWrEn), .RegWrAddr(RegWrAddr), .RegWrData(RegWrData),
    .FlagC(FlagC), .FlagZ(FlagZ), .Done(Done), .IllegalOp(IllegalOp)
  );

  // Register file model: combinational read, write on the clock edge.
  logic [7:0] rf [8];
  logic       pre_we = 1'b0;
  logic [2:0] pre_addr = '0;
  logic [7:0] pre_data = '0;

  initial begin
    for (int i = 0; i < 8; i++) rf[i] = 8'h00;
  end

  always @(posedge Clk) begin
    if (RegWrEn) rf[RegWrAddr] <= RegWrData;
    else if (pre_we) rf[pre_addr] <= pre_data;
  end

  assign RegDataA = rf[RegAddrA];
  assign RegDataB = rf[RegAddrB];

  // ALU model: 0100 ADD (carry out), 0101 SUB (borrow out), logic ops carry 0.
  logic [8:0] alu_wide;
  always_comb begin
    alu_wide = '0;
    case (AluSel)
      4'b0000: alu_wide = {1'b0, AluDataA & AluDataB};
      4'b0001: alu_wide = {1'b0, AluDataA | AluDataB};
      4'b0010: alu_wide = {1'b0, AluDataA ^ AluDataB};
      4'b0100: alu_wide = {1'b0, AluDataA} + {1'b0, AluDataB};
      4'b0101: alu_wide = {1'b0, AluDataA} - {1'b0, AluDataB};
      default: alu_wide = {1'b0, AluDataA};
    endcase
  end
  assign AluDataOut = alu_wide[7:0];
  assign AluCF      = alu_wide[8];
  assign AluZF      = (alu_wide[7:0] == 8'h00);

  typedef struct {
    bit         ill;
    bit         wr;
    logic [2:0] addr;
    logic [7:0] data;
    bit         fc;
    bit         fz;
    int         gap;
  } exp_t;

  exp_t exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops one expectation per Done or IllegalOp pulse.
  always @(negedge Clk) begin
    cyc++;
    if (!Reset) begin
      if (Done || IllegalOp) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_completion: Done=%0b IllegalOp=%0b with no instruction pending", Done, IllegalOp);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (e.ill) begin
            check("illegal_pulse", {Done, IllegalOp, RegWrEn}, 3'b010);
          end else begin
            check("done_pulse", {Done, IllegalOp}, 2'b10);
            check("wr_en", RegWrEn, e.wr);
            if (e.wr) begin
              check("wr_addr", RegWrAddr, e.addr);
              check("wr_data", RegWrData, e.data);
            end
            if (e.gap != 0) check("done_gap", cyc - last_done_cyc, e.gap);
            last_done_cyc = cyc;
          end
          check("flag_c", FlagC, e.fc);
          check("flag_z", FlagZ, e.fz);
          $display("txn ill=%0b wr=%0b addr=%0d data=%02h C=%0b Z=%0b", e.ill, RegWrEn, RegWrAddr, RegWrData, FlagC, FlagZ);
        end
      end else if (RegWrEn) begin
        checks++;
        errors++;
        $display("FAIL stray_write: RegWrEn=1 without Done, addr=%0d", RegWrAddr);
      end
    end
  end

  task automatic preload(input logic [2:0] a, input logic [7:0] d);
    pre_addr = a;
    pre_data = d;
    pre_we   = 1'b1;
    @(posedge Clk);
    #1;
    pre_we = 1'b0;
  endtask

  task automatic issue(input logic [3:0] op, input logic [2:0] dst, input logic [2:0] src,
                       input bit sf, input exp_t e);
    int n;
    InstrOp = op;
    InstrDst = dst;
    InstrSrc = src;
    InstrSetFlags = sf;
    InstrValid = 1'b1;
    n = 0;
    @(negedge Clk);
    while (!InstrReady && n < 20) begin
      @(negedge Clk);
      n++;
    end
    if (!InstrReady) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: InstrReady=0 expected 1 within 20 cycles");
    end else begin
      exp_q.push_back(e);
    end
    @(posedge Clk);
    #1;
    InstrValid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 30) begin
      @(posedge Clk);
      n++;
    end
    check("drain_empty", exp_q.size(), 0);
    repeat (2) @(posedge Clk);
    #1;
  endtask

  function automatic exp_t mk(bit ill, bit wr, logic [2:0] addr, logic [7:0] data,
                              bit fc, bit fz, int gap);
    exp_t e;
    e.ill = ill; e.wr = wr; e.addr = addr; e.data = data;
    e.fc = fc; e.fz = fz; e.gap = gap;
    return e;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge Clk);
    #1;
    check("rst_ready", InstrReady, 1'b1);
    check("rst_outs", {Done, IllegalOp, RegWrEn, AluWriteCZ, FlagC, FlagZ}, 6'b0);
    @(negedge Clk);
    Reset = 1'b0;
    @(posedge Clk);
    #1;

    // 1: ADD no flags
    preload(3'd2, 8'h0F);
    preload(3'd3, 8'h01);
    issue(4'b0100, 3'd2, 3'd3, 1'b0, mk(0, 1, 3'd2, 8'h10, 0, 0, 0));
    drain();

    // 2: ADD with flags, wraps to zero with carry
    preload(3'd1, 8'hFF);
    preload(3'd4, 8'h01);
    issue(4'b0100, 3'd1, 3'd4, 1'b1, mk(0, 1, 3'd1, 8'h00, 1, 1, 0));
    drain();

    // 3: CMP equal: no write, Z=1, C=0
    preload(3'd5, 8'h05);
    preload(3'd6, 8'h05);
    issue(4'b1010, 3'd5, 3'd6, 1'b0, mk(0, 0, 3'd0, 8'h00, 0, 1, 0));
    drain();

    // 4: back-to-back with RAW hazard through R1
    preload(3'd1, 8'h20);
    preload(3'd2, 8'h10);
    preload(3'd3, 8'h45);
    issue(4'b0100, 3'd1, 3'd2, 1'b0, mk(0, 1, 3'd1, 8'h30, 0, 1, 0));
    issue(4'b0101, 3'd3, 3'd1, 1'b1, mk(0, 1, 3'd3, 8'h15, 0, 0, 3));
    drain();

    // 5: illegal opcode
    issue(4'b1100, 3'd1, 3'd2, 1'b1, mk(1, 0, 3'd0, 8'h00, 0, 0, 0));
    @(posedge Clk);
    #1;
    check("ill_one_cycle", IllegalOp, 1'b0);
    check("ill_ready_after", InstrReady, 1'b1);
    drain();

    // 6: set Z via CMP, then reset during EXEC of a flag-setting ADD
    issue(4'b1010, 3'd5, 3'd6, 1'b0, mk(0, 0, 3'd0, 8'h00, 0, 1, 0));
    drain();
    preload(3'd1, 8'hFF);
    preload(3'd4, 8'h01);
    InstrOp = 4'b0100; InstrDst = 3'd1; InstrSrc = 3'd4; InstrSetFlags = 1'b1;
    InstrValid = 1'b1;
    @(posedge Clk);   // accepted from IDLE
    #1;
    InstrValid = 1'b0;
    @(posedge Clk);   // READ -> EXEC
    #1;
    Reset = 1'b1;
    #1;
    check("abort_ready", InstrReady, 1'b1);
    check("abort_flags", {FlagC, FlagZ}, 2'b00);
    check("abort_outs", {Done, RegWrEn}, 2'b00);
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    Reset = 1'b0;
    repeat (6) @(posedge Clk);
    #1;
    check("abort_no_write", rf[1], 8'hFF);

    // Recovery after abort: R2=0x10 + R3=0x15
    issue(4'b0100, 3'd2, 3'd3, 1'b1, mk(0, 1, 3'd2, 8'h25, 0, 0, 0));
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
